game_seq: RTL and testbench
===========================

Name: game_seq

Overview:
- Frame-level game sequencer for the doodle datapath; sits between the frame clock, keyboard keycode, the doodle motion block and the renderer.
- Generates the frame-edge code the doodle block consumes, owns the platform table, and scans doodle-vs-platform collisions once per frame.
- Issues bounce and scroll commands, keeps score, and runs the IDLE/PLAY/OVER game FSM.

Parameters:
- N_PLAT, 8, number of platforms in the table (power of two, 2..16)
- PLAT_W, 10'd30, platform width in pixels
- PLAT_H, 10'd4, platform height in pixels
- DOODLE_W, 10'd10, doodle width
- DOODLE_H, 10'd10, doodle height
- SCROLL_LINE, 10'd80, doodle Y above which the world scrolls down
- DEATH_Y, 10'd228, doodle Y at or below which the game is over
- X_MIN, 10'd80, leftmost playfield X
- X_MAX, 10'd239, rightmost playfield X

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  ~60 Hz frame clock, asynchronous to Clk
- keycode  in  8  current key; 8'h2C is space
- doodle_x  in  10  doodle X position
- doodle_y  in  10  doodle Y position (top edge)
- doodle_vy  in  10  doodle Y speed, two's complement; positive means falling
- frame_clk_edge  out  2  {previous, current} synchronised frame_clk; 2'b01 means rising edge
- doodle_hold  out  1  high whenever state is not PLAY; doodle block treats it as reset
- bounce  out  1  one-Clk pulse requesting a jump impulse
- scroll_amt  out  10  pixels the world moved down this frame, valid with scroll_vld
- scroll_vld  out  1  one-Clk pulse
- score  out  16  total pixels scrolled, saturating
- game_state  out  2  game_state_t encoding
- rd_idx  in  4  renderer platform index
- rd_x, rd_y  out  10 each  platform at rd_idx (combinational read)

Behaviour:
- Reset: frame_clk_edge=2'b00, bounce=0, scroll_vld=0, scroll_amt=0, score=0, state=IDLE, doodle_hold=1.
- Platform i resets to x = X_MIN+16*i, y = 220-28*i. LFSR seed is 16'hACE1.
- Sync: frame_clk passes through 2 flops, then a history flop. frame_clk_edge={hist,sync}.
- Frame tick: asserted on the first Clk where frame_clk_edge==2'b01.
- IDLE: when keycode==8'h2C, reload the reset platform table, clear score, go to PLAY.
- PLAY sub-FSM, advanced only by a frame tick: WAIT -> SCAN -> SCROLL -> CHECK -> WAIT.
  - SCAN: one platform per Clk, i=0..N_PLAT-1 (N_PLAT cycles). A hit requires all of:
    - doodle_vy > 0 (signed compare; vy==0 is not a hit)
    - doodle_x+DOODLE_W > px and doodle_x < px+PLAT_W
    - doodle_y+DOODLE_H >= py and doodle_y+DOODLE_H < py+PLAT_H
  - The first hit pulses bounce once per frame; later hits in the same scan are ignored.
  - SCROLL (1 cycle): if doodle_y < SCROLL_LINE, d = min(SCROLL_LINE-doodle_y, 10'd8); otherwise d=0.
    - Every platform y += d.
    - A platform whose new y > 239 respawns at y = new y-240 and x = X_MIN + (lfsr[6:0] % (X_MAX-X_MIN-PLAT_W)).
    - LFSR steps once per respawn.
    - scroll_amt=d, scroll_vld pulses even when d=0.
    - score += d, saturating at 16'hFFFF.
  - CHECK (1 cycle): doodle_y >= DEATH_Y -> OVER; otherwise WAIT.
- A frame tick that arrives while not in WAIT is dropped. Frame length always exceeds N_PLAT+3 cycles.
- OVER: doodle_hold=1, score frozen. A fresh space press after a release cycle (keycode != 8'h2C) goes to IDLE. A space held continuously does not restart.
- Reset in any state or mid-scan returns to reset values within 1 cycle; no bounce pulse is emitted.
- rd_idx >= N_PLAT returns x=0, y=0.

Optional Feature:
- GAME_PAUSE_EN: adds state PAUSE (encoding 2'd3).
  - PLAY/WAIT with keycode 8'h13 goes to PAUSE.
  - In PAUSE, frame_clk_edge is forced to 2'b00 and doodle_hold=0, so the doodle freezes without resetting.
  - After a release cycle, a new 8'h13 press returns to PLAY/WAIT.
- Without the macro: 8'h13 is ignored and 2'd3 is unused.

Decomposition:
- Package doodle_pkg:
  - game_state_t (IDLE=0, PLAY=1, OVER=2, PAUSE=3)
  - keycode constants KEY_SPACE, KEY_P
  - screen constants SCR_W=320, SCR_H=240
  - platform_t struct {x,y}
- Sub-module lfsr16: Fibonacci taps 16,14,13,11; ports Clk, Reset, step, seed, q.

Test Plan:
- Reset, then frame_clk toggling: frame_clk_edge shows 2'b01 for exactly 1 Clk per rising edge, 3 Clks after the edge; state stays IDLE.
- Space in IDLE: state=PLAY and doodle_hold=0 next cycle. Platform 0 reads rd_x=80, rd_y=220.
- doodle_x=85, doodle_y=212, vy=2 over platform 0 at (80,220), frame tick: exactly one bounce pulse. Same position with vy=-3: no bounce.
- doodle_y=60: scroll_amt=8, score 0->8, platform 0 y=228. Next frame: platform 0 y=236. Following frame: y=244 wraps to 4 with new x in [80,208].
- doodle_y=228 at a tick: state=OVER. Score stays fixed over 5 further frames. Space held from the death frame does not restart; release then press gives IDLE.
- Reset asserted in the middle of SCAN: no bounce, state=IDLE, score=0 on the next cycle.

Source files
------------

// File: rtl/doodle_pkg.sv
// ============================================================================
// Module      : doodle_pkg
// Description : Shared types and constants for the doodle game datapath:
//               game state encoding, keycodes, screen size, the platform
//               record and small helpers for the platform table and LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package doodle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2,
    PAUSE = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;

  localparam logic [9:0] SCR_W = 10'd320;
  localparam logic [9:0] SCR_H = 10'd240;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } platform_t;

  // Start-of-game layout: a staircase climbing up and to the right.
  function automatic platform_t plat_init(input int idx, input logic [9:0] x_min);
    platform_t p;
    p.x = x_min + 10'(16 * idx);
    p.y = 10'(220 - 28 * idx);
    return p;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_seq_lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR used to pick respawn X positions.
//               Loads seed on Reset, advances one step per cycle with step.
// Ports       : Clk, Reset (sync, active-high), step, seed[15:0], q[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
  import doodle_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] state_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= seed;
    end else if (step) begin
      state_q <= lfsr16_next(state_q);
    end
  end

  assign q = state_q;

endmodule

`default_nettype wire

// File: rtl/game_seq.sv
// ============================================================================
// Module      : game_seq
// Description : Frame-level game sequencer. Synchronises frame_clk into the
//               frame-edge code, owns the platform table, scans doodle vs.
//               platform collisions once per frame, issues bounce/scroll,
//               keeps score and runs the IDLE/PLAY/OVER game FSM.
// Ports       : Clk, Reset, frame_clk, keycode[7:0], doodle_x/y/vy[9:0] in;
//               frame_clk_edge[1:0], doodle_hold, bounce, scroll_amt[9:0],
//               scroll_vld, score[15:0], game_state[1:0] out;
//               rd_idx[3:0] in, rd_x/rd_y[9:0] out (combinational read).
// Options     : GAME_PAUSE_EN - adds PAUSE state toggled by keycode 8'h13.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_seq
  import doodle_pkg::*;
#(
  parameter int         N_PLAT      = 8,
  parameter logic [9:0] PLAT_W      = 10'd30,
  parameter logic [9:0] PLAT_H      = 10'd4,
  parameter logic [9:0] DOODLE_W    = 10'd10,
  parameter logic [9:0] DOODLE_H    = 10'd10,
  parameter logic [9:0] SCROLL_LINE = 10'd80,
  parameter logic [9:0] DEATH_Y     = 10'd228,
  parameter logic [9:0] X_MIN       = 10'd80,
  parameter logic [9:0] X_MAX       = 10'd239
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  doodle_x,
  input  logic [9:0]  doodle_y,
  input  logic [9:0]  doodle_vy,
  output logic [1:0]  frame_clk_edge,
  output logic        doodle_hold,
  output logic        bounce,
  output logic [9:0]  scroll_amt,
  output logic        scroll_vld,
  output logic [15:0] score,
  output logic [1:0]  game_state,
  input  logic [3:0]  rd_idx,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y
);

  localparam int         IDX_W    = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
  localparam logic [1:0] P_WAIT   = 2'd0;
  localparam logic [1:0] P_SCAN   = 2'd1;
  localparam logic [1:0] P_SCROLL = 2'd2;
  localparam logic [1:0] P_CHECK  = 2'd3;
  localparam logic [9:0] RSP_SPAN = X_MAX - X_MIN - PLAT_W;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  game_state_t       state_q, state_d;
  logic [1:0]        sub_q, sub_d;
  logic              armed_q, armed_d;

  logic              fsync1_q, fsync2_q, fhist_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_done_q, hit_done_d;
  logic              bounce_q, bounce_d;
  logic              scroll_vld_q, scroll_vld_d;
  logic [9:0]        scroll_amt_q, scroll_amt_d;
  logic [15:0]       score_q, score_d;
  platform_t         plat_q [N_PLAT];
  platform_t         plat_d [N_PLAT];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_tick;
  logic        w_pause_req;
  logic [7:0]  w_exit_key;
  platform_t   w_cur;
  logic [10:0] w_dx_r, w_px_r, w_dy_b, w_py_b;
  logic        w_vy_pos, w_hit;
  logic [9:0]  w_gap, w_d;
  logic [16:0] w_score_sum;
  logic [15:0] w_lfsr_q;
  logic        w_lfsr_step;
  logic [9:0]  w_rsp_x;
  logic        w_lfsr_unused;
  logic        w_rd_ok;
  logic [10:0] w_ny [N_PLAT];

  assign w_tick = ~fhist_q & fsync2_q;

`ifdef GAME_PAUSE_EN
  assign w_pause_req = armed_q && (keycode == KEY_P);
`else
  assign w_pause_req = 1'b0;
`endif

  // Key that leaves the current state; a release of it arms the next press.
  always_comb begin
    w_exit_key = KEY_SPACE;
    if (state_q == PLAY || state_q == PAUSE) w_exit_key = KEY_P;
  end

  // Collision test against the platform selected by the scan index.
  assign w_cur    = plat_q[idx_q];
  assign w_dx_r   = {1'b0, doodle_x} + {1'b0, DOODLE_W};
  assign w_px_r   = {1'b0, w_cur.x} + {1'b0, PLAT_W};
  assign w_dy_b   = {1'b0, doodle_y} + {1'b0, DOODLE_H};
  assign w_py_b   = {1'b0, w_cur.y} + {1'b0, PLAT_H};
  assign w_vy_pos = ~doodle_vy[9] & (doodle_vy != 10'd0);
  assign w_hit    = w_vy_pos
                 && (w_dx_r > {1'b0, w_cur.x}) && ({1'b0, doodle_x} < w_px_r)
                 && (w_dy_b >= {1'b0, w_cur.y}) && (w_dy_b < w_py_b);

  // Scroll distance, clamped to 8 px per frame.
  assign w_gap       = SCROLL_LINE - doodle_y;
  assign w_d         = (doodle_y < SCROLL_LINE) ? ((w_gap > 10'd8) ? 10'd8 : w_gap) : 10'd0;
  assign w_score_sum = {1'b0, score_q} + {7'd0, w_d};

  assign w_rsp_x       = X_MIN + ({3'd0, w_lfsr_q[6:0]} % RSP_SPAN);
  assign w_lfsr_unused = ^w_lfsr_q[15:7];

  // Platforms sit on a fixed 28 px ring spacing and scroll at most 8 px per
  // frame, so at most one of them can wrap per scroll: one LFSR step covers it.
  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .step  (w_lfsr_step),
    .seed  (16'hACE1),
    .q     (w_lfsr_q)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sub_q   <= P_WAIT;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      armed_q <= armed_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    unique case (state_q)
      IDLE: begin
        sub_d = P_WAIT;
        if (keycode == KEY_SPACE) state_d = PLAY;
      end
      PLAY: begin
        case (sub_q)
          P_WAIT: begin
            if (w_pause_req)  state_d = PAUSE;
            else if (w_tick)  sub_d   = P_SCAN;
          end
          P_SCAN:   if (idx_q == IDX_W'(N_PLAT - 1)) sub_d = P_SCROLL;
          P_SCROLL: sub_d = P_CHECK;
          P_CHECK: begin
            sub_d = P_WAIT;
            if (doodle_y >= DEATH_Y) state_d = OVER;
          end
        endcase
      end
      OVER: begin
        sub_d = P_WAIT;
        if (armed_q && keycode == KEY_SPACE) state_d = IDLE;
      end
      PAUSE: begin
        sub_d = P_WAIT;
        if (w_pause_req) state_d = PLAY;
`ifndef GAME_PAUSE_EN
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        sub_d   = P_WAIT;
      end
    endcase
    // Re-arm only after a cycle without the exit key since entering the state.
    armed_d = (state_d != state_q) ? 1'b0 : (armed_q | (keycode != w_exit_key));
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    doodle_hold    = (state_q != PLAY);
    frame_clk_edge = {fhist_q, fsync2_q};
`ifdef GAME_PAUSE_EN
    if (state_q == PAUSE) begin
      doodle_hold    = 1'b0;
      frame_clk_edge = 2'b00;
    end
`endif
  end

  assign game_state = state_q;
  assign bounce     = bounce_q;
  assign scroll_vld = scroll_vld_q;
  assign scroll_amt = scroll_amt_q;
  assign score      = score_q;

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d        = idx_q;
    hit_done_d   = hit_done_q;
    bounce_d     = 1'b0;
    scroll_vld_d = 1'b0;
    scroll_amt_d = scroll_amt_q;
    score_d      = score_q;
    w_lfsr_step  = 1'b0;
    for (int i = 0; i < N_PLAT; i++) begin
      plat_d[i] = plat_q[i];
      w_ny[i]   = {1'b0, plat_q[i].y} + {1'b0, w_d};
    end

    if (state_q == IDLE && state_d == PLAY) begin
      score_d = 16'd0;
      for (int i = 0; i < N_PLAT; i++) plat_d[i] = plat_init(i, X_MIN);
    end

    if (state_q == PLAY) begin
      if (sub_q == P_WAIT && sub_d == P_SCAN) begin
        idx_d      = '0;
        hit_done_d = 1'b0;
      end
      if (sub_q == P_SCAN) begin
        idx_d = idx_q + IDX_W'(1);
        if (w_hit && !hit_done_q) begin
          bounce_d   = 1'b1;
          hit_done_d = 1'b1;
        end
      end
      if (sub_q == P_SCROLL) begin
        scroll_vld_d = 1'b1;
        scroll_amt_d = w_d;
        score_d      = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        for (int i = 0; i < N_PLAT; i++) begin
          if (w_ny[i] >= {1'b0, SCR_H}) begin
            plat_d[i].y = 10'(w_ny[i] - {1'b0, SCR_H});
            plat_d[i].x = w_rsp_x;
            w_lfsr_step = 1'b1;
          end else begin
            plat_d[i].y = w_ny[i][9:0];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsync1_q     <= 1'b0;
      fsync2_q     <= 1'b0;
      fhist_q      <= 1'b0;
      idx_q        <= '0;
      hit_done_q   <= 1'b0;
      bounce_q     <= 1'b0;
      scroll_vld_q <= 1'b0;
      scroll_amt_q <= 10'd0;
      score_q      <= 16'd0;
      for (int i = 0; i < N_PLAT; i++) plat_q[i] <= plat_init(i, X_MIN);
    end else begin
      fsync1_q     <= frame_clk;
      fsync2_q     <= fsync1_q;
      fhist_q      <= fsync2_q;
      idx_q        <= idx_d;
      hit_done_q   <= hit_done_d;
      bounce_q     <= bounce_d;
      scroll_vld_q <= scroll_vld_d;
      scroll_amt_q <= scroll_amt_d;
      score_q      <= score_d;
      for (int i = 0; i < N_PLAT; i++) plat_q[i] <= plat_d[i];
    end
  end

  // --------------------------------------------------------------------------
  // Renderer read port
  // --------------------------------------------------------------------------
  assign w_rd_ok = ({1'b0, rd_idx} < 5'(N_PLAT));
  assign rd_x    = w_rd_ok ? plat_q[rd_idx[IDX_W-1:0]].x : 10'd0;
  assign rd_y    = w_rd_ok ? plat_q[rd_idx[IDX_W-1:0]].y : 10'd0;

endmodule

`default_nettype wire

// File: tb/tb_game_seq.sv
// ============================================================================
// Module      : tb_game_seq
// Description : Self-checking bench for game_seq. Frame stimulus pushes the
//               expected scroll/score/bounce response into a queue; a monitor
//               pops and compares on every scroll_vld pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_seq;

  logic        Clk       = 1'b0;
  logic        Reset     = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode   = 8'h00;
  logic [9:0]  doodle_x  = 10'd150;
  logic [9:0]  doodle_y  = 10'd150;
  logic [9:0]  doodle_vy = 10'd0;
  logic [3:0]  rd_idx    = 4'd0;
  logic [1:0]  frame_clk_edge;
  logic        doodle_hold;
  logic        bounce;
  logic [9:0]  scroll_amt;
  logic        scroll_vld;
  logic [15:0] score;
  logic [1:0]  game_state;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;

  always #5 Clk = ~Clk;

  game_seq dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .keycode        (keycode),
    .doodle_x       (doodle_x),
    .doodle_y       (doodle_y),
    .doodle_vy      (doodle_vy),
    .frame_clk_edge (frame_clk_edge),
    .doodle_hold    (doodle_hold),
    .bounce         (bounce),
    .scroll_amt     (scroll_amt),
    .scroll_vld     (scroll_vld),
    .score          (score),
    .game_state     (game_state),
    .rd_idx         (rd_idx),
    .rd_x           (rd_x),
    .rd_y           (rd_y)
  );

  int checks = 0;
  int errors = 0;
  int bcnt   = 0;
  int first  = -1;
  int n01    = 0;
  bit found  = 0;

  typedef struct {
    logic [9:0]  amt;
    logic [15:0] score;
    int          bounces;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int amt, input int sc, input int b);
    exp_t e;
    e.amt = 10'(amt); e.score = 16'(sc); e.bounces = b;
    exp_q.push_back(e);
  endtask

  task automatic chk_plat(input int idx, input int ex, input int ey);
    rd_idx = 4'(idx);
    #1;
    chk($sformatf("plat%0d_x", idx), rd_x, ex);
    chk($sformatf("plat%0d_y", idx), rd_y, ey);
  endtask

  // One frame: 10 Clk high, 12 low -- long enough for scan+scroll+check.
  task automatic frame();
    frame_clk = 1'b1;
    repeat (10) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (bounce === 1'b1) bcnt++;
    if (scroll_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scroll_unexpected: got amt=%0d score=%0d, required no scroll", scroll_amt, score);
      end else begin
        mon_e = exp_q.pop_front();
        chk("scroll_amt", scroll_amt, mon_e.amt);
        chk("scroll_score", score, mon_e.score);
        chk("bounce_count", bcnt, mon_e.bounces);
        bcnt = 0;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_edge", frame_clk_edge, 2'b00);
    chk("rst_bounce", bounce, 0);
    chk("rst_scroll_vld", scroll_vld, 0);
    chk("rst_scroll_amt", scroll_amt, 0);
    chk("rst_score", score, 0);
    chk("rst_state", game_state, 0);
    chk("rst_hold", doodle_hold, 1);

    // Frame edge code in IDLE
    frame_clk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (frame_clk_edge == 2'b01) begin
        n01++;
        if (first < 0) first = k;
      end
    end
    chk("edge01_width", n01, 1);
    chk("edge01_latency", (first >= 2 && first <= 3), 1);
    chk("idle_after_frame", game_state, 0);
    frame_clk = 1'b0;
    repeat (8) @(negedge Clk);

    // Start game
    keycode = 8'h2C;
    @(negedge Clk);
    keycode = 8'h00;
    chk("start_state", game_state, 1);
    chk("start_hold", doodle_hold, 0);
    chk_plat(0, 80, 220);
    chk_plat(7, 192, 24);
    chk_plat(9, 0, 0);

    // Collision: falling onto platform 0 -> one bounce
    doodle_x = 10'd85; doodle_y = 10'd212; doodle_vy = 10'd2;
    push(0, 0, 1); frame();
    doodle_vy = 10'h3FD;                 // -3, rising
    push(0, 0, 0); frame();
    doodle_vy = 10'd0;                   // vy==0 is not a hit
    push(0, 0, 0); frame();

    // Scrolling
    doodle_x = 10'd150; doodle_y = 10'd60; doodle_vy = 10'h3FD;
    push(8, 8, 0);  frame();
    chk_plat(0, 80, 228);
    push(8, 16, 0); frame();
    chk_plat(0, 80, 236);
    push(8, 24, 0); frame();
    chk_plat(0, 177, 4);                 // seed 16'hACE1 -> lfsr[6:0]=97
    chk("respawn_x_range", (rd_x >= 10'd80 && rd_x <= 10'd208), 1);
    chk_plat(7, 192, 48);
    doodle_y = 10'd75;                   // 5 px from the line
    push(5, 29, 0); frame();
    doodle_y = 10'd80;                   // on the line: no scroll
    push(0, 29, 0); frame();

    // Death boundary
    doodle_y = 10'd227;
    push(0, 29, 0); frame();
    chk("alive_227", game_state, 1);
    doodle_y = 10'd228;
    keycode  = 8'h2C;                    // space held from the death frame on
    push(0, 29, 0); frame();
    chk("over_state", game_state, 2);
    chk("over_hold", doodle_hold, 1);
    doodle_y = 10'd60;
    for (int f = 0; f < 5; f++) begin
      frame();
      chk("over_score_frozen", score, 29);
      chk("over_held_space", game_state, 2);
    end
    keycode = 8'h00;
    @(negedge Clk);
    keycode = 8'h2C;
    @(negedge Clk);
    keycode = 8'h00;
    chk("over_to_idle", game_state, 0);
    repeat (3) @(negedge Clk);
    chk("idle_stays", game_state, 0);

    // New game, one scroll, then Reset in the middle of a scan with a hit pending
    keycode = 8'h2C;
    @(negedge Clk);
    keycode = 8'h00;
    chk("restart_state", game_state, 1);
    chk("restart_score", score, 0);
    chk_plat(0, 80, 220);
    doodle_x = 10'd150; doodle_y = 10'd60; doodle_vy = 10'h3FD;
    push(8, 8, 0); frame();
    doodle_x = 10'd85; doodle_y = 10'd220; doodle_vy = 10'd2;
    frame_clk = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge Clk);
      if (frame_clk_edge == 2'b01) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no 2'b01 edge in 10 cycles, required one");
    end
    @(negedge Clk);                      // first SCAN cycle (platform 0)
    Reset = 1'b1;
    @(negedge Clk);
    chk("midscan_bounce", bounce, 0);
    chk("midscan_state", game_state, 0);
    chk("midscan_score", score, 0);
    chk("midscan_hold", doodle_hold, 1);
    Reset = 1'b0;
    frame_clk = 1'b0;
    repeat (20) @(negedge Clk);
    chk("midscan_no_bounce_seen", bcnt, 0);
    chk("post_reset_idle", game_state, 0);
    chk("pending_scrolls", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
